// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: immediate-format select codes and default datapath width.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] IMM_I   = 4'b0000;
    localparam logic [3:0] IMM_S   = 4'b0001;
    localparam logic [3:0] IMM_B   = 4'b0010;
    localparam logic [3:0] IMM_U   = 4'b0011;
    localparam logic [3:0] IMM_J   = 4'b0100;
    localparam logic [3:0] IMM_Z   = 4'b0101;
    localparam logic [3:0] IMM_CI  = 4'b1000;
    localparam logic [3:0] IMM_CIW = 4'b1001;
    localparam logic [3:0] IMM_CL  = 4'b1010;
    localparam logic [3:0] IMM_CJ  = 4'b1011;
    localparam logic [3:0] IMM_CB  = 4'b1100;
    localparam logic [3:0] IMM_CSS = 4'b1101;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Upstream (in_*) and downstream (out_*) valid/ready channels of the immediate generator stage.
interface imm_gen_stage_if #(
    parameter int XLEN  = riscv_pkg::XLEN_DEFAULT,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [3:0]       in_immsrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, in_instr, in_immsrc, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_immsrc, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extraction/extension for all RISC-V formats.
// Compressed formats are decoded only when IMM_GEN_RVC_EN is defined.
module imm_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr_i,
    input  logic [3:0]      immsrc_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [31:0] imm32;

    // Every format is first built as a 32-bit value already sign/zero-extended
    // to bit 31, so widening to XLEN is a plain sign extension for all of them.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        imm32     = '0;
        illegal_o = 1'b0;
        unique case (immsrc_i)
            IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm32 = {instr_i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            IMM_Z:   imm32 = {27'b0, instr_i[19:15]};
`ifdef IMM_GEN_RVC_EN
            IMM_CI:  imm32 = {{26{instr_i[12]}}, instr_i[12], instr_i[6:2]};
            IMM_CIW: imm32 = {22'b0, instr_i[10:7], instr_i[12:11], instr_i[5],
                              instr_i[6], 2'b00};
            IMM_CL:  imm32 = {25'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00};
            IMM_CJ:  imm32 = {{20{instr_i[12]}}, instr_i[12], instr_i[8],
                              instr_i[10:9], instr_i[6], instr_i[7], instr_i[2],
                              instr_i[11], instr_i[5:3], 1'b0};
            IMM_CB:  imm32 = {{23{instr_i[12]}}, instr_i[12], instr_i[6:5],
                              instr_i[2], instr_i[11:10], instr_i[4:3], 1'b0};
            IMM_CSS: imm32 = {24'b0, instr_i[8:7], instr_i[12:9], 2'b00};
`endif
            default: illegal_o = 1'b1;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

`ifdef IMM_GEN_RVC_EN
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^instr_i[1:0];
`else
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^instr_i[6:0];
`endif

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator stage: output register plus one skid entry,
// full throughput with a fully registered in_ready. Honours IMM_GEN_RVC_EN via imm_decode.
module imm_gen_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 32
) (
    input logic                clk,
    input logic                rst_n,
    imm_gen_stage_if.slave     bus
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    entry_t          in_entry;
    entry_t          out_q, out_d, skid_q, skid_d;
    logic            out_valid_q, out_valid_d;
    logic            skid_full_q, skid_full_d;
    logic            in_ready_q;
    logic            xfer_in, out_load;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (bus.in_instr),
        .immsrc_i  (bus.in_immsrc),
        .imm_o     (dec_imm),
        .illegal_o (dec_illegal)
    );

    assign in_entry = '{imm: dec_imm, tag: bus.in_tag, illegal: dec_illegal};
    assign xfer_in  = bus.in_valid && in_ready_q;
    assign out_load = !out_valid_q || bus.out_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (out_load) begin
            // The skid entry is older than anything on the input, so it goes first.
            if (skid_full_q) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                skid_full_d = 1'b0;
            end else begin
                out_valid_d = xfer_in;
                if (xfer_in) out_d = in_entry;
            end
        end else if (xfer_in) begin
            skid_d      = in_entry;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too, so out_imm/out_tag read 0 after reset.
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all state updates on the same edge.
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= !skid_full_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_tag     = out_q.tag;
    assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed self-checking bench for imm_gen_stage at XLEN=32 and XLEN=64.
module tb_imm_gen_stage;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  src;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) if32 ();
    imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) if64 ();

    imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive32(input logic v, input logic [31:0] instr,
                           input logic [3:0] src, input logic [31:0] tag);
        if32.in_valid  = v;
        if32.in_instr  = instr;
        if32.in_immsrc = src;
        if32.in_tag    = tag;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (if32.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", if32.in_ready); end
        checks++; if (if32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", if32.out_valid); end
        checks++; if (if32.out_imm !== 32'h0) begin errors++; $display("FAIL reset_out_imm: got %h expected 0", if32.out_imm); end
        checks++; if (if32.out_tag !== 32'h0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", if32.out_tag); end
        checks++; if (if32.out_illegal !== 1'b0) begin errors++; $display("FAIL reset_out_illegal: got %b expected 0", if32.out_illegal); end
        checks++; if (if64.out_imm !== 64'h0) begin errors++; $display("FAIL reset_out_imm64: got %h expected 0", if64.out_imm); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (if32.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", if32.in_ready); end
        checks++; if (if32.out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b expected 0", if32.out_valid); end
    endtask

    task automatic test_formats32;
        vec_t v[12];
        v[0]  = '{32'hFFF00093, 4'b0000, 32'hFFFFFFFF, 1'b0};
        v[1]  = '{32'hFE112E23, 4'b0001, 32'hFFFFFFFC, 1'b0};
        v[2]  = '{32'hFFFFF06F, 4'b0100, 32'hFFFFFFFE, 1'b0};
        v[3]  = '{32'hFE000E63, 4'b0010, 32'hFFFFF7FC, 1'b0};
        v[4]  = '{32'hFE000EE3, 4'b0010, 32'hFFFFFFFC, 1'b0};
        v[5]  = '{32'h800000B7, 4'b0011, 32'h80000000, 1'b0};
        v[6]  = '{32'h0007D073, 4'b0101, 32'h0000000F, 1'b0};
        v[7]  = '{32'hFFFFFFFF, 4'b0111, 32'h00000000, 1'b1};
        v[8]  = '{32'hFFFFFFFF, 4'b1111, 32'h00000000, 1'b1};
`ifdef IMM_GEN_RVC_EN
        v[9]  = '{32'h0000BFFD, 4'b1011, 32'hFFFFFFFE, 1'b0};
        v[10] = '{32'h0000107C, 4'b1000, 32'hFFFFFFFF, 1'b0};
        v[11] = '{32'h00001F80, 4'b1101, 32'h000000FC, 1'b0};
`else
        v[9]  = '{32'h0000BFFD, 4'b1011, 32'h00000000, 1'b1};
        v[10] = '{32'h0000107C, 4'b1000, 32'h00000000, 1'b1};
        v[11] = '{32'h00001F80, 4'b1101, 32'h00000000, 1'b1};
`endif
        if32.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            drive32(1'b1, v[i].instr, v[i].src, 32'h1000 + i);
            @(posedge clk); #1;
            drive32(1'b0, 32'h0, 4'b0000, 32'h0);
            @(negedge clk);
            checks++; if (if32.out_valid !== 1'b1) begin errors++; $display("FAIL fmt%0d_valid: got %b expected 1", i, if32.out_valid); end
            checks++; if (if32.out_imm !== v[i].exp) begin errors++; $display("FAIL fmt%0d_imm: got %h expected %h", i, if32.out_imm, v[i].exp); end
            checks++; if (if32.out_illegal !== v[i].ill) begin errors++; $display("FAIL fmt%0d_illegal: got %b expected %b", i, if32.out_illegal, v[i].ill); end
            checks++; if (if32.out_tag !== 32'h1000 + i) begin errors++; $display("FAIL fmt%0d_tag: got %h expected %h", i, if32.out_tag, 32'h1000 + i); end
        end
    endtask

    task automatic test_xlen64;
        if64.out_ready = 1'b1;
        @(posedge clk); #1;
        if64.in_valid = 1'b1; if64.in_instr = 32'h800000B7; if64.in_immsrc = 4'b0011; if64.in_tag = 32'h64;
        @(posedge clk); #1;
        if64.in_instr = 32'h0007D073; if64.in_immsrc = 4'b0101; if64.in_tag = 32'h65;
        @(negedge clk);
        checks++; if (if64.out_imm !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL x64_u_imm: got %h expected ffffffff80000000", if64.out_imm); end
        @(posedge clk); #1;
        if64.in_instr = 32'hFFF00093; if64.in_immsrc = 4'b0000; if64.in_tag = 32'h66;
        @(negedge clk);
        checks++; if (if64.out_imm !== 64'h000000000000000F) begin errors++; $display("FAIL x64_z_imm: got %h expected 000000000000000f", if64.out_imm); end
        checks++; if (if64.out_tag !== 32'h65) begin errors++; $display("FAIL x64_z_tag: got %h expected 65", if64.out_tag); end
        @(posedge clk); #1;
        if64.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (if64.out_imm !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL x64_i_imm: got %h expected ffffffffffffffff", if64.out_imm); end
        @(negedge clk);
        checks++; if (if64.out_valid !== 1'b0) begin errors++; $display("FAIL x64_drain_valid: got %b expected 0", if64.out_valid); end
    endtask

    task automatic test_back_to_back;
        if32.out_ready = 1'b1;
        @(posedge clk); #1;
        drive32(1'b1, 32'hFFF00093, 4'b0000, 32'h2001);
        @(posedge clk); #1;
        drive32(1'b1, 32'h00500093, 4'b0000, 32'h2002);
        @(negedge clk);
        checks++; if (if32.out_valid !== 1'b1 || if32.out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_first: got v=%b imm=%h expected v=1 imm=ffffffff", if32.out_valid, if32.out_imm); end
        @(posedge clk); #1;
        drive32(1'b0, 32'h0, 4'b0000, 32'h0);
        @(negedge clk);
        checks++; if (if32.out_valid !== 1'b1 || if32.out_imm !== 32'h00000005) begin errors++; $display("FAIL b2b_second: got v=%b imm=%h expected v=1 imm=00000005", if32.out_valid, if32.out_imm); end
        checks++; if (if32.out_tag !== 32'h2002) begin errors++; $display("FAIL b2b_second_tag: got %h expected 2002", if32.out_tag); end
        @(negedge clk);
        checks++; if (if32.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", if32.out_valid); end
    endtask

    task automatic test_backpressure;
        if32.out_ready = 1'b0;
        @(posedge clk); #1;
        drive32(1'b1, 32'h00100093, 4'b0000, 32'hA);
        @(posedge clk); #1;
        drive32(1'b1, 32'h00200093, 4'b0000, 32'hB);
        @(negedge clk);
        checks++; if (if32.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a: got %b expected 1", if32.in_ready); end
        @(posedge clk); #1;
        drive32(1'b1, 32'h00300093, 4'b0000, 32'hC);
        @(negedge clk);
        checks++; if (if32.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_b: got %b expected 0", if32.in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (if32.out_valid !== 1'b1 || if32.out_tag !== 32'hA || if32.out_imm !== 32'h1) begin
                errors++; $display("FAIL bp_stall%0d: got v=%b tag=%h imm=%h expected v=1 tag=a imm=1", k, if32.out_valid, if32.out_tag, if32.out_imm);
            end
            checks++; if (if32.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d_ready: got %b expected 0", k, if32.in_ready); end
        end
        if32.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (if32.out_valid !== 1'b1 || if32.out_tag !== 32'hB || if32.out_imm !== 32'h2) begin errors++; $display("FAIL bp_deliver_b: got v=%b tag=%h imm=%h expected v=1 tag=b imm=2", if32.out_valid, if32.out_tag, if32.out_imm); end
        checks++; if (if32.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_reopen: got %b expected 1", if32.in_ready); end
        @(posedge clk); #1;
        drive32(1'b0, 32'h0, 4'b0000, 32'h0);
        @(negedge clk);
        checks++; if (if32.out_valid !== 1'b1 || if32.out_tag !== 32'hC || if32.out_imm !== 32'h3) begin errors++; $display("FAIL bp_deliver_c: got v=%b tag=%h imm=%h expected v=1 tag=c imm=3", if32.out_valid, if32.out_tag, if32.out_imm); end
        @(negedge clk);
        checks++; if (if32.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", if32.out_valid); end
    endtask

    task automatic test_reset_midstream;
        if32.out_ready = 1'b0;
        @(posedge clk); #1;
        drive32(1'b1, 32'h00D00093, 4'b0000, 32'hD);
        @(posedge clk); #1;
        drive32(1'b1, 32'h00E00093, 4'b0000, 32'hE);
        @(posedge clk); #1;
        drive32(1'b0, 32'h0, 4'b0000, 32'h0);
        @(negedge clk);
        checks++; if (if32.in_ready !== 1'b0 || if32.out_tag !== 32'hD) begin errors++; $display("FAIL rst_full: got ready=%b tag=%h expected ready=0 tag=d", if32.in_ready, if32.out_tag); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (if32.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", if32.out_valid); end
        checks++; if (if32.in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b expected 0", if32.in_ready); end
        rst_n = 1'b1;
        if32.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (if32.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release_ready: got %b expected 1", if32.in_ready); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (if32.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale%0d: got v=%b tag=%h expected v=0", k, if32.out_valid, if32.out_tag); end
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive32(1'b0, 32'h0, 4'b0000, 32'h0);
        if32.out_ready = 1'b1;
        if64.in_valid  = 1'b0;
        if64.in_instr  = 32'h0;
        if64.in_immsrc = 4'b0000;
        if64.in_tag    = 32'h0;
        if64.out_ready = 1'b1;

        test_reset();
        test_formats32();
        test_xlen64();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
